// File: rtl/mips_cpu_harvard_fetch.sv
// -----------------------------------------------------------------------------
// mips_cpu_harvard_fetch
//
// Instruction fetch stage for a Harvard MIPS core. The PC register drives the
// instruction memory address directly. Each enabled edge registers the
// returned word and its address for decode. A taken jump or branch redirects
// the PC after the delay slot has been captured. A jump to address 0 is the
// halt request: the delay slot is still presented, and then the stage drains
// and parks in HALTED until reset.
//
// Optional feature (macro FETCH_ALIGN_FAULT_EN):
//   When defined, a jump to a target that is not word aligned sets a sticky
//   instr_fault flag and halts through the DRAIN path.
//   When undefined, misaligned targets are silently aligned and
//   o_instr_fault is tied to 0.
//
// Ports:
//   i_clk              clock, rising-edge active
//   i_reset            asynchronous active-low reset
//   i_clk_enable       1 = advance this edge, 0 = hold all state (stall)
//   o_instr_address    current PC to instruction memory
//   i_instr_readdata   combinational memory data for o_instr_address
//   i_jump_req         taken jump or branch resolved by decode this cycle
//   i_jump_target      jump destination, valid with i_jump_req
//   o_instr_word       registered instruction for decode
//   o_instr_pc         address o_instr_word was fetched from
//   o_instr_valid      o_instr_word / o_instr_pc hold a live instruction
//   o_active           1 while running, 0 once halted
//   o_instr_fault      sticky misaligned-target fault
//
// State   | meaning
// --------+------------------------------------------------------------------
// RUN     | fetching; the PC advances by 4 or is redirected by a jump
// DRAIN   | the halt delay slot was presented; invalidate and go inactive
// HALTED  | terminal until reset; PC parked at 0
// -----------------------------------------------------------------------------
module mips_cpu_harvard_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clk_enable,
    output logic [31:0] o_instr_address,
    input  logic [31:0] i_instr_readdata,
    input  logic        i_jump_req,
    input  logic [31:0] i_jump_target,
    output logic [31:0] o_instr_word,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    output logic        o_active,
    output logic        o_instr_fault
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_instr_word;
    logic [31:0] w_instr_word_next;
    logic [31:0] r_instr_pc;
    logic [31:0] w_instr_pc_next;
    logic        r_instr_valid;
    logic        w_instr_valid_next;
    logic        r_active;
    logic        w_active_next;

    logic [31:0] w_target_aligned;
    logic        w_halt_target;

    assign w_target_aligned = {i_jump_target[31:2], 2'b00};
    // Halt is requested by the exact target 0, not by the aligned value.
    assign w_halt_target    = (i_jump_target == 32'h0000_0000);

`ifdef FETCH_ALIGN_FAULT_EN
    logic r_fault;
    logic w_fault_next;
    logic w_misaligned;

    assign w_misaligned = (i_jump_target[1:0] != 2'b00);
`endif

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_instr_word_next  = r_instr_word;
        w_instr_pc_next    = r_instr_pc;
        w_instr_valid_next = r_instr_valid;
        w_active_next      = r_active;
`ifdef FETCH_ALIGN_FAULT_EN
        w_fault_next       = r_fault;
`endif

        if (i_clk_enable) begin
            case (r_state)
                ST_RUN: begin
                    // The word captured on a jump edge is the delay slot.
                    w_instr_word_next  = i_instr_readdata;
                    w_instr_pc_next    = r_pc;
                    w_instr_valid_next = 1'b1;
                    if (i_jump_req) begin
`ifdef FETCH_ALIGN_FAULT_EN
                        if (w_misaligned) begin
                            w_fault_next = 1'b1;
                            w_pc_next    = 32'h0000_0000;
                            w_state_next = ST_DRAIN;
                        end else begin
                            w_pc_next = w_target_aligned;
                            if (w_halt_target)
                                w_state_next = ST_DRAIN;
                        end
`else
                        w_pc_next = w_target_aligned;
                        if (w_halt_target)
                            w_state_next = ST_DRAIN;
`endif
                    end else begin
                        w_pc_next = r_pc + 32'd4;
                    end
                end
                ST_DRAIN: begin
                    w_instr_valid_next = 1'b0;
                    w_active_next      = 1'b0;
                    w_state_next       = ST_HALTED;
                end
                ST_HALTED: begin
                    w_instr_valid_next = 1'b0;
                    w_active_next      = 1'b0;
                end
                default: begin
                    // Unused encoding: park safely in HALTED.
                    w_pc_next          = 32'h0000_0000;
                    w_instr_valid_next = 1'b0;
                    w_active_next      = 1'b0;
                    w_state_next       = ST_HALTED;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_VECTOR;
            r_instr_word  <= 32'h0000_0000;
            r_instr_pc    <= 32'h0000_0000;
            r_instr_valid <= 1'b0;
            r_active      <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_instr_word  <= w_instr_word_next;
            r_instr_pc    <= w_instr_pc_next;
            r_instr_valid <= w_instr_valid_next;
            r_active      <= w_active_next;
        end
    end

`ifdef FETCH_ALIGN_FAULT_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            r_fault <= 1'b0;
        else
            r_fault <= w_fault_next;
    end

    assign o_instr_fault = r_fault;
`else
    assign o_instr_fault = 1'b0;
`endif

    assign o_instr_address = r_pc;
    assign o_instr_word    = r_instr_word;
    assign o_instr_pc      = r_instr_pc;
    assign o_instr_valid   = r_instr_valid;
    assign o_active        = r_active;

endmodule

// File: tb/tb_mips_cpu_harvard_fetch.sv
module tb_mips_cpu_harvard_fetch;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        jump_req;
    logic [31:0] jump_target;
    logic [31:0] instr_word;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        active;
    logic        instr_fault;

    int checks = 0;
    int errors = 0;

    mips_cpu_harvard_fetch #(.RESET_VECTOR(32'hBFC00000)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_clk_enable     (clk_enable),
        .o_instr_address  (instr_address),
        .i_instr_readdata (instr_readdata),
        .i_jump_req       (jump_req),
        .i_jump_target    (jump_target),
        .o_instr_word     (instr_word),
        .o_instr_pc       (instr_pc),
        .o_instr_valid    (instr_valid),
        .o_active         (active),
        .o_instr_fault    (instr_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: a fixed word at the reset vector, a simple
    // address-derived pattern everywhere else.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'hBFC00000)
            return 32'h25420045;
        return a ^ 32'h5A5A5A5A;
    endfunction

    assign instr_readdata = mem(instr_address);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b0;
        clk_enable  = 1'b1;
        jump_req    = 1'b0;
        jump_target = 32'h0;
        repeat (2) step();

        check("rst_addr",  instr_address, 32'hBFC00000);
        check("rst_word",  instr_word,    32'h0);
        check("rst_pc",    instr_pc,      32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_active",{31'b0, active},      32'd1);
        check("rst_fault", {31'b0, instr_fault}, 32'd0);

        // First fetch after release
        reset = 1'b1;
        step();
        check("f1_word",  instr_word,    32'h25420045);
        check("f1_pc",    instr_pc,      32'hBFC00000);
        check("f1_valid", {31'b0, instr_valid}, 32'd1);
        check("f1_addr",  instr_address, 32'hBFC00004);

        // Stall for three edges; a jump request during the stall is ignored
        clk_enable  = 1'b0;
        jump_req    = 1'b1;
        jump_target = 32'h12345678;
        repeat (3) step();
        check("stall_addr",  instr_address, 32'hBFC00004);
        check("stall_word",  instr_word,    32'h25420045);
        check("stall_pc",    instr_pc,      32'hBFC00000);
        check("stall_valid", {31'b0, instr_valid}, 32'd1);

        // Resume at the held PC
        clk_enable = 1'b1;
        jump_req   = 1'b0;
        step();
        check("res_pc",   instr_pc,      32'hBFC00004);
        check("res_word", instr_word,    mem(32'hBFC00004));
        check("res_addr", instr_address, 32'hBFC00008);

        // Jump to 0x1000 from PC 0xBFC00008: delay slot captured first
        jump_req    = 1'b1;
        jump_target = 32'h00001000;
        step();
        check("j_slot_pc", instr_pc,      32'hBFC00008);
        check("j_addr",    instr_address, 32'h00001000);
        check("j_active",  {31'b0, active}, 32'd1);

        jump_req = 1'b0;
        step();
        check("j_tgt_pc",   instr_pc,      32'h00001000);
        check("j_tgt_word", instr_word,    mem(32'h00001000));
        check("j_tgt_addr", instr_address, 32'h00001004);

        // Misaligned target
        jump_req    = 1'b1;
        jump_target = 32'h00001002;
        step();
        check("mis_slot_pc", instr_pc, 32'h00001004);
`ifdef FETCH_ALIGN_FAULT_EN
        check("mis_fault", {31'b0, instr_fault}, 32'd1);
        check("mis_addr",  instr_address, 32'h0);
        jump_req = 1'b0;
        step();
        check("mis_active2", {31'b0, active},      32'd0);
        check("mis_fault2",  {31'b0, instr_fault}, 32'd1);
        check("mis_valid2",  {31'b0, instr_valid}, 32'd0);
`else
        check("mis_fault", {31'b0, instr_fault}, 32'd0);
        check("mis_addr",  instr_address, 32'h00001000);
        jump_req = 1'b0;
        step();
        check("mis_addr2",   instr_address, 32'h00001004);
        check("mis_active2", {31'b0, active}, 32'd1);
`endif

        // Asynchronous reset mid-run
        reset = 1'b0;
        #1;
        check("arst_addr",   instr_address, 32'hBFC00000);
        check("arst_fault",  {31'b0, instr_fault}, 32'd0);
        check("arst_active", {31'b0, active},      32'd1);
        check("arst_valid",  {31'b0, instr_valid}, 32'd0);

        // Jump request held during reset is discarded
        jump_req    = 1'b1;
        jump_target = 32'hFFFFFFFC;
        step();
        check("rjmp_addr", instr_address, 32'hBFC00000);
        reset = 1'b1;
        step();
        check("w_slot_pc", instr_pc,      32'hBFC00000);
        check("w_addr",    instr_address, 32'hFFFFFFFC);

        // PC wrap from 0xFFFFFFFC to 0 without halting
        jump_req = 1'b0;
        step();
        check("wrap_pc",     instr_pc,      32'hFFFFFFFC);
        check("wrap_word",   instr_word,    mem(32'hFFFFFFFC));
        check("wrap_addr",   instr_address, 32'h0);
        check("wrap_active", {31'b0, active},      32'd1);
        check("wrap_valid",  {31'b0, instr_valid}, 32'd1);
        step();
        check("wrap2_pc",   instr_pc,      32'h0);
        check("wrap2_addr", instr_address, 32'h4);

        // Halt: jump to 0, delay slot valid for exactly one cycle
        jump_req    = 1'b1;
        jump_target = 32'h0;
        step();
        check("h_slot_pc",    instr_pc, 32'h4);
        check("h_slot_valid", {31'b0, instr_valid}, 32'd1);
        check("h_slot_active",{31'b0, active},      32'd1);
        check("h_slot_addr",  instr_address, 32'h0);

        jump_target = 32'h00002000;
        step();
        check("h_valid",  {31'b0, instr_valid}, 32'd0);
        check("h_active", {31'b0, active},      32'd0);
        check("h_addr",   instr_address, 32'h0);
        check("h_pc",     instr_pc,      32'h4);
        step();
        check("h2_addr",   instr_address, 32'h0);
        check("h2_valid",  {31'b0, instr_valid}, 32'd0);
        check("h2_active", {31'b0, active},      32'd0);

        // Reset from HALTED
        jump_req = 1'b0;
        reset    = 1'b0;
        #2;
        check("hr_addr",   instr_address, 32'hBFC00000);
        check("hr_active", {31'b0, active},      32'd1);
        check("hr_valid",  {31'b0, instr_valid}, 32'd0);
        check("hr_word",   instr_word,    32'h0);

        // Outputs hold reset values until the first enabled edge
        clk_enable = 1'b0;
        step();
        reset = 1'b1;
        repeat (2) step();
        check("hold_word",  instr_word,    32'h0);
        check("hold_valid", {31'b0, instr_valid}, 32'd0);
        check("hold_addr",  instr_address, 32'hBFC00000);
        clk_enable = 1'b1;
        step();
        check("rf_word",  instr_word,    32'h25420045);
        check("rf_valid", {31'b0, instr_valid}, 32'd1);
        check("rf_addr",  instr_address, 32'hBFC00004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
